// File: rtl/rv_check_pkg.sv
// rv_check_pkg: shared types and constants for the stream checker.
// Holds the checker state enum, LFSR width/taps/seed and one step function.
package rv_check_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int LFSR_W = 16;

   // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;

   function automatic logic [LFSR_W-1:0] lfsr_step(
      input logic [LFSR_W-1:0] s
   );
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/rv_lfsr16.sv
// rv_lfsr16: 16-bit Fibonacci LFSR, advances when en=1.
// Ports: clk, rst (sync, active high, loads SEED), en, state (current value).
module rv_lfsr16
   import rv_check_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic [LFSR_W-1:0] state
);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SEED;
      end else if (en) begin
         state <= lfsr_step(state);
      end
   end

endmodule

// File: rtl/rv_stream_checker.sv
// rv_stream_checker: ready/valid sink that checks for an incrementing stream.
// Ports: clk, rst (sync, active high); in_data/in_valid/in_ready stream;
//   start, stall_en, target controls; xfer_count, err_count, err_flag,
//   last_bad_data, done, proto_err_count status.
// Optional: define RV_CHECKER_PROTOCOL_CHECK_EN to count valid-withdrawn
//   and data-unstable violations; otherwise proto_err_count is tied to 0.
module rv_stream_checker
   import rv_check_pkg::*;
#(
   parameter int                DATA_WIDTH = 8,
   parameter int                CNT_WIDTH  = 16,
   parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_SEED_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  start,
   input  logic                  stall_en,
   input  logic [CNT_WIDTH-1:0]  target,
   output logic [CNT_WIDTH-1:0]  xfer_count,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic                  err_flag,
   output logic [DATA_WIDTH-1:0] last_bad_data,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  proto_err_count
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t                state;
   logic [LFSR_W-1:0]     lfsr_q;
   logic [LFSR_W-1:0]     lfsr_nxt;
   logic                  lfsr_en;
   logic [DATA_WIDTH-1:0] exp_data;
   logic                  xfer;
   logic                  mismatch;
   logic                  hit;
   logic                  go;
   logic                  rdy_run;
   logic [CNT_WIDTH-1:0]  xfer_inc;
   logic [CNT_WIDTH-1:0]  err_inc;

   assign lfsr_en = (state == RUN);

   rv_lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .en    (lfsr_en),
      .state (lfsr_q)
   );

   // Value the LFSR holds after this edge; ready follows its bit 0
   assign lfsr_nxt = lfsr_en ? lfsr_step(lfsr_q) : lfsr_q;
   assign rdy_run  = stall_en ? lfsr_nxt[0] : 1'b1;

   assign xfer     = in_valid & in_ready;
   assign mismatch = (in_data != exp_data);
   assign go       = start & (state != RUN);

   assign xfer_inc = (xfer_count == CNT_MAX) ?
                     xfer_count : xfer_count + CNT_WIDTH'(1);
   assign err_inc  = (err_count == CNT_MAX) ?
                     err_count : err_count + CNT_WIDTH'(1);

   assign hit = xfer && (target != '0) && (xfer_inc == target);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         in_ready      <= 1'b0;
         done          <= 1'b0;
         err_flag      <= 1'b0;
         xfer_count    <= '0;
         err_count     <= '0;
         last_bad_data <= '0;
         exp_data      <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= RUN;
                  in_ready   <= rdy_run;
                  done       <= 1'b0;
                  err_flag   <= 1'b0;
                  xfer_count <= '0;
                  err_count  <= '0;
                  exp_data   <= '0;
               end
            end
            RUN: begin
               if (xfer) begin
                  xfer_count <= xfer_inc;
                  // Resync on every transfer: one gap = one error
                  exp_data   <= in_data + DATA_WIDTH'(1);
                  if (mismatch) begin
                     err_count     <= err_inc;
                     err_flag      <= 1'b1;
                     last_bad_data <= in_data;
                  end
               end
               if (hit) begin
                  state    <= DONE;
                  in_ready <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  in_ready <= rdy_run;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

`ifdef RV_CHECKER_PROTOCOL_CHECK_EN
   logic                  prev_vld;
   logic                  prev_rdy;
   logic [DATA_WIDTH-1:0] prev_data;
   logic                  viol;
   logic [CNT_WIDTH-1:0]  proto_q;

   // A stalled beat must stay valid with the same data
   assign viol = (state == RUN) && prev_vld && !prev_rdy &&
                 (!in_valid || (in_data != prev_data));

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_vld  <= 1'b0;
         prev_rdy  <= 1'b0;
         prev_data <= '0;
         proto_q   <= '0;
      end else begin
         prev_vld  <= (state == RUN) & in_valid;
         prev_rdy  <= in_ready;
         prev_data <= in_data;
         if (go) begin
            proto_q <= '0;
         end else if (viol && (proto_q != CNT_MAX)) begin
            proto_q <= proto_q + CNT_WIDTH'(1);
         end
      end
   end

   assign proto_err_count = proto_q;
`else
   assign proto_err_count = '0;
`endif

endmodule

// File: tb/tb_rv_stream_checker.sv
// tb_rv_stream_checker: directed bench for rv_stream_checker.
// Drives and samples on the falling edge; ready checked against an LFSR model.
module tb_rv_stream_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        start = 1'b0;
   logic        stall_en = 1'b0;
   logic [15:0] target = '0;
   logic [15:0] xfer_count;
   logic [15:0] err_count;
   logic        err_flag;
   logic [7:0]  last_bad_data;
   logic        done;
   logic [15:0] proto_err_count;

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0]  src [0:511];
   logic [15:0] m;
   logic        m_run;
   logic        m_stall;
   logic        exp_rdy;
   int          m_xfers;
   int          m_tgt;

   always #5 clk = ~clk;

   rv_stream_checker dut (
      .clk             (clk),
      .rst             (rst),
      .in_data         (in_data),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .start           (start),
      .stall_en        (stall_en),
      .target          (target),
      .xfer_count      (xfer_count),
      .err_count       (err_count),
      .err_flag        (err_flag),
      .last_bad_data   (last_bad_data),
      .done            (done),
      .proto_err_count (proto_err_count)
   );

   function automatic logic [15:0] m_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      @(negedge clk);
      rst = 1'b0;
      m = 16'hACE1;
      m_run = 1'b0;
      exp_rdy = 1'b0;
      m_xfers = 0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rdy"}, in_ready, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_flag"}, err_flag, 0);
      chk({tag, "_xfer"}, xfer_count, 0);
      chk({tag, "_err"}, err_count, 0);
      chk({tag, "_bad"}, last_bad_data, 0);
      chk({tag, "_proto"}, proto_err_count, 0);
   endtask

   // LFSR is not advanced on the start edge (it only steps while running)
   task automatic do_start(input logic s, input logic [15:0] t);
      stall_en = s;
      target = t;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      m_run = 1'b1;
      m_stall = s;
      m_tgt = int'(t);
      m_xfers = 0;
      exp_rdy = s ? m[0] : 1'b1;
   endtask

   task automatic send(input int n, input int lim, input string tag);
      int   i;
      int   c;
      logic rdy;
      i = 0;
      c = 0;
      in_valid = 1'b1;
      in_data = src[0];
      while (i < n && c < lim) begin
         rdy = in_ready;
         chk({tag, "_rdy"}, rdy, exp_rdy);
         @(negedge clk);
         c++;
         if (m_run) m = m_step(m);
         if (rdy) begin
            i++;
            m_xfers++;
            if (m_tgt != 0 && m_xfers == m_tgt) m_run = 1'b0;
         end
         exp_rdy = m_run ? (m_stall ? m[0] : 1'b1) : 1'b0;
         if (i < n) in_data = src[i];
         else in_valid = 1'b0;
      end
      chk({tag, "_budget"}, i, n);
   endtask

   initial begin
      int   c;
      logic rdy;
      int   p1;
      int   p2;

      // Reset state
      do_reset();
      chk_reset("rst");

      // Free flow, target 10
      for (int i = 0; i < 10; i++) src[i] = 8'(i);
      do_start(1'b0, 16'd10);
      send(10, 40, "ff");
      chk("ff_xfer", xfer_count, 10);
      chk("ff_err", err_count, 0);
      chk("ff_done", done, 1);
      chk("ff_rdy0", in_ready, 0);
      @(negedge clk);
      chk("ff_rdy_hold", in_ready, 0);
      chk("ff_done_hold", done, 1);

      // Backpressure, target 20
      do_reset();
      for (int i = 0; i < 20; i++) src[i] = 8'(i);
      do_start(1'b1, 16'd20);
      send(20, 200, "bp");
      chk("bp_xfer", xfer_count, 20);
      chk("bp_err", err_count, 0);
      chk("bp_done", done, 1);

      // Dropped item (5 missing)
      do_reset();
      src[0] = 8'd0; src[1] = 8'd1; src[2] = 8'd2; src[3] = 8'd3;
      src[4] = 8'd4; src[5] = 8'd6; src[6] = 8'd7; src[7] = 8'd8;
      do_start(1'b0, 16'd8);
      send(8, 40, "drop");
      chk("drop_err", err_count, 1);
      chk("drop_flag", err_flag, 1);
      chk("drop_bad", last_bad_data, 8'd6);
      chk("drop_xfer", xfer_count, 8);
      chk("drop_done", done, 1);

      // Wrap-around 255 -> 0
      do_reset();
      for (int i = 0; i < 300; i++) src[i] = 8'(i);
      do_start(1'b0, 16'd300);
      send(300, 400, "wrap");
      chk("wrap_xfer", xfer_count, 300);
      chk("wrap_err", err_count, 0);
      chk("wrap_done", done, 1);

      // Reset mid-run, then restart from exp=0
      do_reset();
      for (int i = 0; i < 3; i++) src[i] = 8'(i);
      do_start(1'b0, 16'd0);
      send(3, 20, "mid");
      chk("mid_xfer", xfer_count, 3);
      do_reset();
      chk_reset("mid_rst");
      do_start(1'b0, 16'd0);
      send(3, 20, "mid2");
      chk("mid2_xfer", xfer_count, 3);
      chk("mid2_err", err_count, 0);
      chk("mid2_done", done, 0);
      chk("mid2_rdy", in_ready, 1);

      // Protocol: valid withdrawn, then data changed, during stalls
`ifdef RV_CHECKER_PROTOCOL_CHECK_EN
      p1 = 1;
      p2 = 2;
`else
      p1 = 0;
      p2 = 0;
`endif
      do_reset();
      do_start(1'b1, 16'd0);
      in_valid = 1'b0;
      c = 0;
      while (in_ready !== 1'b0 && c < 50) begin
         @(negedge clk);
         c++;
      end
      chk("pv_find", c < 50, 1);
      in_valid = 1'b1;
      in_data = 8'h55;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pv_proto", proto_err_count, p1);
      chk("pv_xfer", xfer_count, 0);

      c = 0;
      while (in_ready !== 1'b0 && c < 50) begin
         @(negedge clk);
         c++;
      end
      chk("pd_find", c < 50, 1);
      in_valid = 1'b1;
      in_data = 8'h10;
      @(negedge clk);
      in_data = 8'h11;
      c = 0;
      do begin
         rdy = in_ready;
         @(negedge clk);
         c++;
      end while (!rdy && c < 50);
      in_valid = 1'b0;
      chk("pd_hold", c < 50, 1);
      @(negedge clk);
      chk("pd_proto", proto_err_count, p2);
      chk("pd_xfer", xfer_count, 1);
      chk("pd_err", err_count, 1);
      chk("pd_bad", last_bad_data, 8'h11);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_stream_checker.md
Name: rv_stream_checker

Overview:
- Consuming end of the team's ready/valid stream protocol: the counterpart to the data source in buffer/source/sink test harnesses.
- Accepts transfers and drives in_ready with optional pseudo-random backpressure from an LFSR.
- Checks that received data is an incrementing sequence and reports transfer/error counts and run completion.
- Sits downstream of a buffer under test; fully synthesisable so it runs in simulation and on FPGA.

Parameters:
- DATA_WIDTH, 8, stream data width.
- CNT_WIDTH, 16, width of the transfer, error and target counters.
- LFSR_SEED, 16'hACE1, backpressure LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  stream data.
- in_valid  in  1  stream valid.
- in_ready  out  1  stream ready, registered.
- start  in  1  begin a run (pulse).
- stall_en  in  1  1 = LFSR backpressure, 0 = ready held high while running.
- target  in  CNT_WIDTH  transfers per run; 0 = run forever.
- xfer_count  out  CNT_WIDTH  accepted transfers this run.
- err_count  out  CNT_WIDTH  sequence mismatches this run.
- err_flag  out  1  sticky: any mismatch this run.
- last_bad_data  out  DATA_WIDTH  data of the most recent mismatch.
- done  out  1  run complete.
- proto_err_count  out  CNT_WIDTH  protocol violations (see Optional Feature).

Behaviour:
- Reset (rst=1 at a rising edge):
  - Next cycle: state IDLE, in_ready=0, done=0, err_flag=0.
  - All counts, last_bad_data and the expected value (exp) are 0; LFSR=LFSR_SEED.
  - Reset mid-run has the same effect; nothing carries over.
- A transfer occurs on any rising edge with in_valid&in_ready=1.
- IDLE:
  - in_ready=0.
  - start=1 -> RUN. The in_ready register loads its RUN value on the same edge, so ready can be high the cycle after start.
- RUN:
  - LFSR advances every cycle: 16-bit Fibonacci, taps 16,14,13,11.
  - Next in_ready = stall_en ? next LFSR bit0 : 1.
  - start is ignored.
- Transfer handling:
  - xfer_count increments, saturating at all-ones.
  - If in_data != exp: err_count increments (saturating), err_flag=1, last_bad_data=in_data.
  - exp is then set to in_data+1 mod 2^DATA_WIDTH, whether or not the data matched. This resync means one dropped or duplicated item gives exactly one error.
  - Wrap from all-ones to 0 is a legal increment.
- Target reached:
  - If target!=0 and a transfer makes xfer_count==target: -> DONE on that edge, in_ready=0 next cycle, done=1 next cycle.
  - target is sampled continuously; changing it mid-run is the user's responsibility.
- DONE:
  - in_ready=0, done=1, counts held.
  - start=1 -> RUN with xfer_count, err_count, err_flag, proto_err_count and exp cleared; the LFSR is not reseeded.
- Backpressure is applied only via in_ready. in_valid is never required to wait for in_ready.

Optional Feature:
- Macro: RV_CHECKER_PROTOCOL_CHECK_EN.
- Defined: in RUN, registers the previous cycle's in_valid, in_ready and in_data. proto_err_count increments (saturating) when the previous cycle had in_valid=1 and in_ready=0 and either:
  - in_valid is now 0 (valid withdrawn), or
  - in_data has changed (data unstable).
  - Both conditions in one cycle count once.
- Not defined: proto_err_count tied to 0 and no extra registers.

Decomposition:
- Package rv_check_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - LFSR width and tap-mask constant;
  - default seed constant.
- One sub-module: rv_lfsr16, with clk, rst, en, seed parameter and a 16-bit state output; also reused by a future backpressured source.

Test Plan:
- Free-flow run: rst, start, stall_en=0, target=10, source sends 0..9 back-to-back.
  -> in_ready=1 from the cycle after start; done=1 the cycle after the 10th transfer; xfer_count=10, err_count=0, in_ready=0 thereafter.
- Backpressure: stall_en=1, target=20, default seed.
  -> in_ready matches the bench LFSR model cycle for cycle; 20 transfers, err_count=0.
- Dropped item: source sends 0,1,2,3,4,6,7,8 with target=8.
  -> err_count=1, err_flag=1, last_bad_data=6, no further errors.
- Wrap-around: DATA_WIDTH=8, target=300, incrementing data.
  -> 255->0 gives no error; xfer_count=300, done=1.
- Reset mid-run: rst=1 after 3 transfers.
  -> next cycle all outputs at reset values; start again and counting restarts at 0 with exp=0.
- With RV_CHECKER_PROTOCOL_CHECK_EN, stall_en=1:
  - source drops in_valid during a stall -> proto_err_count=1;
  - source changes in_data during a stall -> proto_err_count=2.
  - Without the macro, the same stimulus -> proto_err_count stays 0.
